id_ctrl_stage: RTL

//  Registered decode/control stage for the RV32I core, with an optional M extension.

---
 rtl/id_ctrl_stage.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage
//   Registered decode/control stage for the RV32I core with optional M extension.
//   Decodes an accepted instruction into the one-hot control bundle, flags illegal
//   encodings, holds M-ops for MULDIV_LAT cycles, and presents the bundle under a
//   valid/ready handshake between fetch (upstream) and execute (downstream).
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               kill held/pending instruction (branch redirect)
//   in_valid/in_ready   upstream handshake; in_instr, in_pc instruction and its pc
//   out_valid/out_ready downstream handshake; out_instr, out_pc registered copies
//   MemWrite, MemRead, RegWrite, ALUSrc, MemtoReg, ALUControl, BranchControl,
//   Mem_mode, Mem_read_us, md_op, illegal    registered control bundle
module id_ctrl_stage #(
  parameter int unsigned XLEN       = 32,
  parameter bit          EN_M       = 1'b1,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            RegWrite,
  output logic [3:0]      ALUSrc,
  output logic [3:0]      MemtoReg,
  output logic [4:0]      ALUControl,
  output logic [3:0]      BranchControl,
  output logic [2:0]      Mem_mode,
  output logic            Mem_read_us,
  output logic            md_op,
  output logic            illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);
  localparam bit         MD_WAIT  = (MULDIV_LAT > 1);

  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  // ---------------- decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_load, is_store;
  logic        dec_mw, dec_mr, dec_rw, dec_us, dec_md, dec_ill;
  logic [3:0]  dec_alusrc, dec_m2r, dec_br;
  logic [4:0]  dec_aluc;
  logic [2:0]  dec_mm;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_alusrc = '0;
    dec_m2r    = '0;
    dec_aluc   = '0;
    dec_br     = '0;
    dec_mm     = '0;
    dec_us     = 1'b0;
    dec_mw     = 1'b0;
    dec_mr     = 1'b0;
    dec_rw     = 1'b0;
    dec_md     = 1'b0;
    dec_ill    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    case (opcode)
      OP_R: begin
        dec_alusrc = 4'b0001;
        dec_m2r    = 4'b0001;
        dec_aluc   = 5'b00001;
        dec_rw     = 1'b1;
        case (funct7)
          7'b0000000: begin end
          7'b0100000: dec_ill = !(funct3 == 3'b000 || funct3 == 3'b101);
          7'b0000001: begin
            if (EN_M) dec_md  = 1'b1;
            else      dec_ill = 1'b1;
          end
          default:    dec_ill = 1'b1;
        endcase
      end
      OP_I: begin
        dec_alusrc = 4'b0010;
        dec_m2r    = 4'b0001;
        dec_aluc   = 5'b00010;
        dec_rw     = 1'b1;
      end
      OP_LOAD: begin
        is_load    = 1'b1;
        dec_alusrc = 4'b0010;
        dec_m2r    = 4'b0010;
        dec_aluc   = 5'b00100;
        dec_rw     = 1'b1;
        dec_mr     = 1'b1;
        dec_ill    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        is_store   = 1'b1;
        dec_alusrc = 4'b0100;
        dec_aluc   = 5'b01000;
        dec_mw     = 1'b1;
        dec_ill    = (funct3 >= 3'b011);
      end
      OP_B: begin
        dec_br  = 4'b0001;
        dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JALR: begin
        dec_m2r = 4'b0100;
        dec_br  = 4'b0010;
        dec_rw  = 1'b1;
        dec_ill = (funct3 != 3'b000);
      end
      OP_JAL: begin
        dec_m2r = 4'b0100;
        dec_br  = 4'b0100;
        dec_rw  = 1'b1;
      end
      OP_LUI: begin
        dec_alusrc = 4'b1000;
        dec_m2r    = 4'b0001;
        dec_aluc   = 5'b10000;
        dec_rw     = 1'b1;
      end
      OP_AUIPC: begin
        dec_m2r = 4'b1000;
        dec_br  = 4'b1000;
        dec_rw  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase

    if (is_load || is_store) begin
      case (funct3[1:0])
        2'b00:   dec_mm = 3'b001;
        2'b01:   dec_mm = 3'b010;
        2'b10:   dec_mm = 3'b100;
        default: dec_mm = 3'b000;
      endcase
    end
    dec_us = is_load && (funct3 == 3'b100 || funct3 == 3'b101);

    if (dec_ill) begin
      dec_rw = 1'b0;
      dec_mr = 1'b0;
      dec_mw = 1'b0;
      dec_md = 1'b0;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // The WAIT exit is taken when the counter is about to reach 0 so that out_valid
  // rises exactly MULDIV_LAT cycles after accept; a latency of 1 skips WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        EMPTY, FULL: begin
          if (accept) begin
            if (dec_md && MD_WAIT) begin
              state_d = WAIT;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = FULL;
            end
          end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
          end
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    out_valid = !rst && (state_q == FULL);
    in_ready  = !rst && !flush &&
                ((state_q == EMPTY) || ((state_q == FULL) && out_ready));
  end

  assign accept = in_valid && in_ready;

  // ---------------- bundle registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr     <= '0;
      out_pc        <= '0;
      MemWrite      <= 1'b0;
      MemRead       <= 1'b0;
      RegWrite      <= 1'b0;
      ALUSrc        <= '0;
      MemtoReg      <= '0;
      ALUControl    <= '0;
      BranchControl <= '0;
      Mem_mode      <= '0;
      Mem_read_us   <= 1'b0;
      md_op         <= 1'b0;
      illegal       <= 1'b0;
    end else if (accept) begin
      out_instr     <= in_instr;
      out_pc        <= in_pc;
      MemWrite      <= dec_mw;
      MemRead       <= dec_mr;
      RegWrite      <= dec_rw;
      ALUSrc        <= dec_alusrc;
      MemtoReg      <= dec_m2r;
      ALUControl    <= dec_aluc;
      BranchControl <= dec_br;
      Mem_mode      <= dec_mm;
      Mem_read_us   <= dec_us;
      md_op         <= dec_md;
      illegal       <= dec_ill;
    end
  end

endmodule
